// File: rtl/result_out_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : result_out_arbiter_if
// Description : Bundles the lane request/data bus, the output register
//               handshake and the frame status signals of result_out_arbiter.
//               The master modport is the arbiter side; the slave modport is
//               the environment side (adder lanes, output register, sink).
// Revision    : 1.0  initial release
// ============================================================================
interface result_out_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
);

  // Lane side
  logic [NUM_REQ-1:0]        req_in;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        gnt_out;

  // Output register side
  logic [DATA_W-1:0]         reg_data_out;
  logic                      reg_wr_out;
  logic                      reg_read_out;
  logic                      reg_input_rdy_in;
  logic                      reg_output_rdy_in;

  // Downstream sink and status
  logic                      sink_rdy_in;
  logic                      frame_valid_out;
  logic [ID_W-1:0]           owner_id_out;
  logic                      busy_out;

  modport master (
    input  req_in,
    input  data_in,
    input  reg_input_rdy_in,
    input  reg_output_rdy_in,
    input  sink_rdy_in,
    output gnt_out,
    output reg_data_out,
    output reg_wr_out,
    output reg_read_out,
    output frame_valid_out,
    output owner_id_out,
    output busy_out
  );

  modport slave (
    output req_in,
    output data_in,
    output reg_input_rdy_in,
    output reg_output_rdy_in,
    output sink_rdy_in,
    input  gnt_out,
    input  reg_data_out,
    input  reg_wr_out,
    input  reg_read_out,
    input  frame_valid_out,
    input  owner_id_out,
    input  busy_out
  );

endinterface
`default_nettype wire

// File: rtl/result_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : result_out_arbiter
// Description : Shares one parallel-in/serial-out result register between
//               NUM_REQ adder lanes. Picks a requesting lane, loads its word
//               into the output register, drains it bit-serially while the
//               sink is ready, then re-arms for the next lane.
//               Build option: define ARB_FIXED_PRIO_EN for fixed priority
//               (lowest lane index wins); default is round-robin.
// Revision    : 1.0  initial release
// ============================================================================
module result_out_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  result_out_arbiter_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Index of the final serial bit of a word and of the highest lane.
  localparam logic [5:0]      LAST_BIT  = 6'(DATA_W - 1);
  localparam logic [ID_W-1:0] LAST_LANE = ID_W'(NUM_REQ - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   owner_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_nxt;
  logic [5:0]        bit_cnt;
  logic [5:0]        bit_cnt_nxt;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_nxt;

  logic [ID_W-1:0]   winner;
  logic              found;
  logic              consume;

  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0]  data_out;
  logic               reg_wr;
  logic               reg_read;
  logic               frame_valid;

  // Unpack the flat lane bus into one word per lane.
  logic [DATA_W-1:0] lane_word [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_word[g] = bus.data_in[g*DATA_W +: DATA_W];
  end

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-indexed requesting lane wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_in[ID_W'(i)]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end
`else
  int              cand;
  logic [ID_W-1:0] cand_id;

  // Round-robin: scan lanes starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand    = 0;
    cand_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_id = ID_W'(cand);
      if (!found && bus.req_in[cand_id]) begin
        found  = 1'b1;
        winner = cand_id;
      end
    end
  end
`endif

  // Next-state and output decode; every output defaults to its idle value.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_nxt      = rr_ptr;
    bit_cnt_nxt = bit_cnt;
    word_nxt    = word;
    gnt         = '0;
    data_out    = word;
    reg_wr      = 1'b0;
    reg_read    = 1'b0;
    frame_valid = 1'b0;
    consume     = 1'b0;

    case (state)
      S_IDLE: begin
        // Only start a frame when the output register can take the word.
        if (found && bus.reg_input_rdy_in) begin
          owner_nxt = winner;
          state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        // Word is forwarded straight from the lane in this cycle and latched
        // so reg_data_out stays stable for the rest of the frame.
        reg_wr     = 1'b1;
        data_out   = lane_word[owner];
        word_nxt   = lane_word[owner];
        gnt[owner] = 1'b1;
        state_nxt  = S_WAIT;
      end

      S_WAIT: begin
        if (bus.reg_output_rdy_in) begin
          bit_cnt_nxt = '0;
          state_nxt   = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Read enable follows the sink combinationally; a stalled sink
        // holds the frame with the bit count frozen.
        frame_valid = 1'b1;
        reg_read    = bus.sink_rdy_in;
        consume     = bus.sink_rdy_in && bus.reg_output_rdy_in;
        if (consume) begin
          bit_cnt_nxt = bit_cnt + 6'd1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Re-arm once the output register is empty and ready again.
        if (bus.reg_input_rdy_in && !bus.reg_output_rdy_in) begin
          state_nxt = S_IDLE;
          word_nxt  = '0;
`ifdef ARB_FIXED_PRIO_EN
          rr_nxt    = '0;
`else
          rr_nxt    = (owner == LAST_LANE) ? '0 : owner + 1'b1;
`endif
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= S_IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      bit_cnt <= '0;
      word    <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      rr_ptr  <= rr_nxt;
      bit_cnt <= bit_cnt_nxt;
      word    <= word_nxt;
    end
  end

  assign bus.gnt_out         = gnt;
  assign bus.reg_data_out    = data_out;
  assign bus.reg_wr_out      = reg_wr;
  assign bus.reg_read_out    = reg_read;
  assign bus.frame_valid_out = frame_valid;
  assign bus.owner_id_out    = owner;
  assign bus.busy_out        = (state != S_IDLE);

endmodule
`default_nettype wire
